// File: rtl/ex_pkg.sv
// Package: ex_pkg
// Purpose: shared constants, FSM state type and header helpers for the
//          execution-core arbiter slice (ex_arbiter, rr_arbiter, ex_arbiter_if).
// Contents:
//    WORD_W       data word width on every packet port
//    HDR_LEN_LSB  bit position of the LEN field inside a header word
//    HDR_LEN_W    width of the LEN field (also the width of the length counters)
//    ex_state_t   arbiter FSM states
//    ERR_TMO      err[] bit index for the response timeout pulse
//    ERR_STRAY    err[] bit index for the stray core word pulse
package ex_pkg;

   localparam int WORD_W      = 32;
   localparam int HDR_LEN_LSB = 0;
   localparam int HDR_LEN_W   = 8;

   localparam int ERR_W     = 2;
   localparam int ERR_TMO   = 0;
   localparam int ERR_STRAY = 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_FWD      = 2'd1,
      S_WAIT_RSP = 2'd2,
      S_RSP      = 2'd3
   } ex_state_t;

   // Payload word count carried in a header word.
   function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [WORD_W-1:0] word);
      return word[HDR_LEN_LSB +: HDR_LEN_W];
   endfunction

endpackage

// File: rtl/ex_arbiter_if.sv
// Interface: ex_arbiter_if
// Purpose: requester-side bundle of the execution-core arbiter.
// Signals:
//    req_valid  NREQ     requester i presents a word
//    req_data   32*NREQ  requester i word in slice [32*i+31:32*i]
//    req_ready  NREQ     word of requester i accepted when valid & ready
//    rsp_valid  NREQ     one-hot response strobe (no backpressure)
//    rsp_data   32       response word shared by all requesters
// Modports:
//    master  requester side (drives req_valid/req_data)
//    slave   arbiter side (drives req_ready/rsp_valid/rsp_data)
interface ex_arbiter_if
   import ex_pkg::*;
#(
   parameter int NREQ = 2
);

   logic [NREQ-1:0]        req_valid;
   logic [WORD_W*NREQ-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        rsp_valid;
   logic [WORD_W-1:0]      rsp_data;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );

endinterface

// File: rtl/ex_arbiter_rr_arbiter.sv
// Module: rr_arbiter
// Purpose: purely combinational round-robin pick. Returns the first active
//          request at or after the pointer, wrapping around NREQ.
// Ports:
//    req        in   NREQ  request vector
//    ptr        in   2     round-robin start index (always < NREQ)
//    grant      out  NREQ  one-hot grant (zero when no request)
//    grant_idx  out  2     index of the granted requester
//    any        out  1     at least one request active
module rr_arbiter
#(
   parameter int NREQ = 2
)
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic [NREQ-1:0] grant,
   output logic [1:0]      grant_idx,
   output logic            any
);

   // cand[k] is the requester index examined at rotation offset k from ptr.
   logic [1:0] cand [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = (int'(ptr) + gi >= NREQ) ? 2'(int'(ptr) + gi - NREQ)
                                                 : 2'(int'(ptr) + gi);
   end

   logic [NREQ-1:0] shifted;

   // Scan from the farthest offset down so the nearest active request wins.
   always_comb begin
      grant_idx = '0;
      any       = 1'b0;
      shifted   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         shifted = req >> cand[k];
         if (shifted[0]) begin
            grant_idx = cand[k];
            any       = 1'b1;
         end
      end
      grant = any ? (NREQ'(1) << grant_idx) : '0;
   end

endmodule

// File: rtl/ex_arbiter.sv
// Module: ex_arbiter
// Purpose: shares one execution core between NREQ packet requesters. A granted
//          requester's whole packet is forwarded word-by-word to the core, then
//          the core's response packet is routed back to that requester.
//          Packets: header word (LEN = hdr[7:0]) followed by LEN payload words.
// Parameters:
//    NREQ     number of requesters (2..4)
//    TMO_CYC  idle cycles tolerated while waiting for a response word
// Ports:
//    clk                  in   1   rising-edge clock
//    reset                in   1   asynchronous active-low reset
//    req_bus              slave    requester-side bundle (ex_arbiter_if)
//    out_interface        out  32  word to the core
//    valid_out_interface  out  1   out_interface qualifier
//    in_interface         in   32  word from the core
//    valid_in_interface   in   1   in_interface qualifier
//    busy                 out  1   high outside IDLE
//    grant_id             out  2   current owner index
//    err                  out  2   pulses: [0] response timeout, [1] stray core word
module ex_arbiter
   import ex_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int TMO_CYC = 1024
)
(
   input  logic              clk,
   input  logic              reset,
   ex_arbiter_if.slave       req_bus,
   output logic [WORD_W-1:0] out_interface,
   output logic              valid_out_interface,
   input  logic [WORD_W-1:0] in_interface,
   input  logic              valid_in_interface,
   output logic              busy,
   output logic [1:0]        grant_id,
   output logic [ERR_W-1:0]  err
);

   localparam int TMO_W = $clog2(TMO_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   ex_state_t            state_reg, state_next;
   logic [1:0]           grant_reg, grant_next;
   logic [1:0]           rr_ptr_reg, rr_ptr_next;
   logic                 hdr_pend_reg, hdr_pend_next;
   logic [HDR_LEN_W-1:0] fwd_rem_reg, fwd_rem_next;
   logic [HDR_LEN_W-1:0] rsp_rem_reg, rsp_rem_next;
   logic [TMO_W-1:0]     tmo_cnt_reg, tmo_cnt_next;
   logic [WORD_W-1:0]    out_data_reg, out_data_next;
   logic                 out_valid_reg, out_valid_next;
   logic [WORD_W-1:0]    rsp_data_reg, rsp_data_next;
   logic [NREQ-1:0]      rsp_valid_reg, rsp_valid_next;
   logic [ERR_W-1:0]     err_reg, err_next;

   logic [NREQ-1:0]      req_ready_int;
   logic [NREQ-1:0]      arb_grant;
   logic [1:0]           arb_idx;
   logic                 arb_any;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req       (req_bus.req_valid),
      .ptr       (rr_ptr_reg),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   // Owner decode and owner word select as an AND-OR mux.
   logic [NREQ-1:0]   grant_oh;
   logic [WORD_W-1:0] masked_word [NREQ];
   logic [WORD_W-1:0] req_word;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner
      assign grant_oh[gi]    = (grant_reg == 2'(gi));
      assign masked_word[gi] = grant_oh[gi] ? req_bus.req_data[WORD_W*gi +: WORD_W] : '0;
   end

   always_comb begin
      req_word = '0;
      for (int k = 0; k < NREQ; k++) begin
         req_word = req_word | masked_word[k];
      end
   end

   logic                 fwd_accept;
   logic [1:0]           grant_inc;
   logic [HDR_LEN_W-1:0] req_len;
   logic [HDR_LEN_W-1:0] in_len;

   assign fwd_accept = (state_reg == S_FWD) && |(req_bus.req_valid & grant_oh);
   assign grant_inc  = (grant_reg == 2'(NREQ - 1)) ? 2'd0 : grant_reg + 2'd1;
   assign req_len    = hdr_len(req_word);
   assign in_len     = hdr_len(in_interface);

   always_comb begin
      state_next     = state_reg;
      grant_next     = grant_reg;
      rr_ptr_next    = rr_ptr_reg;
      hdr_pend_next  = hdr_pend_reg;
      fwd_rem_next   = fwd_rem_reg;
      rsp_rem_next   = rsp_rem_reg;
      tmo_cnt_next   = '0;
      out_data_next  = out_data_reg;
      out_valid_next = 1'b0;
      rsp_data_next  = rsp_data_reg;
      rsp_valid_next = '0;
      err_next       = '0;
      req_ready_int  = '0;

      case (state_reg)
         S_IDLE: begin
            if (arb_any) begin
               grant_next    = arb_idx;
               hdr_pend_next = 1'b1;
               state_next    = S_FWD;
            end
            if (valid_in_interface) begin
               err_next[ERR_STRAY] = 1'b1;
            end
         end

         S_FWD: begin
            req_ready_int = grant_oh;
            if (valid_in_interface) begin
               err_next[ERR_STRAY] = 1'b1;
            end
            if (fwd_accept) begin
               out_valid_next = 1'b1;
               out_data_next  = req_word;
               if (hdr_pend_reg) begin
                  hdr_pend_next = 1'b0;
                  fwd_rem_next  = req_len;
                  if (req_len == '0) begin
                     state_next = S_WAIT_RSP;
                  end
               end else begin
                  fwd_rem_next = fwd_rem_reg - 1'b1;
                  if (fwd_rem_reg == HDR_LEN_W'(1)) begin
                     state_next = S_WAIT_RSP;
                  end
               end
            end
         end

         S_WAIT_RSP, S_RSP: begin
            if (valid_in_interface) begin
               rsp_valid_next = grant_oh;
               rsp_data_next  = in_interface;
               if (state_reg == S_WAIT_RSP) begin
                  rsp_rem_next = in_len;
                  if (in_len == '0) begin
                     state_next  = S_IDLE;
                     rr_ptr_next = grant_inc;
                  end else begin
                     state_next = S_RSP;
                  end
               end else begin
                  rsp_rem_next = rsp_rem_reg - 1'b1;
                  if (rsp_rem_reg == HDR_LEN_W'(1)) begin
                     state_next  = S_IDLE;
                     rr_ptr_next = grant_inc;
                  end
               end
            end else if (tmo_cnt_reg == TMO_LAST) begin
               // The TMO_CYC-th consecutive idle cycle: abandon the response.
               err_next[ERR_TMO] = 1'b1;
               state_next        = S_IDLE;
               rr_ptr_next       = grant_inc;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         grant_reg     <= '0;
         rr_ptr_reg    <= '0;
         hdr_pend_reg  <= 1'b0;
         fwd_rem_reg   <= '0;
         rsp_rem_reg   <= '0;
         tmo_cnt_reg   <= '0;
         out_data_reg  <= '0;
         out_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
         rsp_valid_reg <= '0;
         err_reg       <= '0;
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         rr_ptr_reg    <= rr_ptr_next;
         hdr_pend_reg  <= hdr_pend_next;
         fwd_rem_reg   <= fwd_rem_next;
         rsp_rem_reg   <= rsp_rem_next;
         tmo_cnt_reg   <= tmo_cnt_next;
         out_data_reg  <= out_data_next;
         out_valid_reg <= out_valid_next;
         rsp_data_reg  <= rsp_data_next;
         rsp_valid_reg <= rsp_valid_next;
         err_reg       <= err_next;
      end
   end

   assign req_bus.req_ready  = req_ready_int;
   assign req_bus.rsp_valid  = rsp_valid_reg;
   assign req_bus.rsp_data   = rsp_data_reg;
   assign out_interface       = out_data_reg;
   assign valid_out_interface = out_valid_reg;
   assign busy                = (state_reg != S_IDLE);
   assign grant_id            = grant_reg;
   assign err                 = err_reg;

endmodule

// File: tb/tb_ex_arbiter.sv
// Testbench: tb_ex_arbiter
// Purpose: directed stimulus for ex_arbiter with a scoreboard. Expected forwarded
//          words and response words are queued when stimulus is issued; a
//          negedge monitor pops and compares whenever the DUT presents a word.
module tb_ex_arbiter;
   import ex_pkg::*;

   localparam int NREQ    = 2;
   localparam int TMO_CYC = 1024;
   localparam int BUDGET  = 3000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] out_interface;
   logic        valid_out_interface;
   logic [31:0] in_interface = '0;
   logic        valid_in_interface = 1'b0;
   logic        busy;
   logic [1:0]  grant_id;
   logic [1:0]  err;

   logic        tb_valid [NREQ];
   logic [31:0] tb_data  [NREQ];

   always #5 clk = ~clk;

   ex_arbiter_if #(.NREQ(NREQ)) req_bus ();

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_drv
      assign req_bus.req_valid[gi]          = tb_valid[gi];
      assign req_bus.req_data[32*gi +: 32]  = tb_data[gi];
   end

   ex_arbiter #(.NREQ(NREQ), .TMO_CYC(TMO_CYC)) dut (
      .clk                 (clk),
      .reset               (reset),
      .req_bus             (req_bus),
      .out_interface       (out_interface),
      .valid_out_interface (valid_out_interface),
      .in_interface        (in_interface),
      .valid_in_interface  (valid_in_interface),
      .busy                (busy),
      .grant_id            (grant_id),
      .err                 (err)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard queues: {owner index, word}
   logic [33:0] exp_out_q [$];
   logic [33:0] exp_rsp_q [$];

   int n_out = 0, n_rsp = 0, n_err0 = 0, n_err1 = 0;
   int cyc = 0, last_out_cyc = 0, err0_cyc = 0;
   logic acc_prev = 1'b0;

   // Monitor: every forwarded word must be the next expected one from the right
   // owner, exactly one cycle after its acceptance; every response likewise.
   always @(negedge clk) begin
      logic [33:0] e;
      cyc++;
      if (valid_out_interface || acc_prev) begin
         check("out_latency", 64'(valid_out_interface), 64'(acc_prev));
      end
      acc_prev = |(req_bus.req_valid & req_bus.req_ready);
      if (valid_out_interface) begin
         n_out++;
         last_out_cyc = cyc;
         if (exp_out_q.size() == 0) begin
            check("out_unexpected", 64'(exp_out_q.size()), 64'd1);
         end else begin
            e = exp_out_q.pop_front();
            $display("out  word=%08h owner=%0d", out_interface, grant_id);
            check("out_word", 64'(out_interface), 64'(e[31:0]));
            check("out_owner", 64'(grant_id), 64'(e[33:32]));
         end
      end
      if (req_bus.rsp_valid != '0) begin
         n_rsp++;
         if (exp_rsp_q.size() == 0) begin
            check("rsp_unexpected", 64'(exp_rsp_q.size()), 64'd1);
         end else begin
            e = exp_rsp_q.pop_front();
            $display("rsp  word=%08h strobe=%b", req_bus.rsp_data, req_bus.rsp_valid);
            check("rsp_strobe", 64'(req_bus.rsp_valid), 64'd1 << e[33:32]);
            check("rsp_data", 64'(req_bus.rsp_data), 64'(e[31:0]));
         end
      end
      if (err[ERR_TMO]) begin
         n_err0++;
         err0_cyc = cyc;
      end
      if (err[ERR_STRAY]) begin
         n_err1++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_out(input int r, input logic [31:0] hdr, input logic [31:0] base);
      exp_out_q.push_back({2'(r), hdr});
      for (int k = 1; k <= int'(hdr[7:0]); k++) begin
         exp_out_q.push_back({2'(r), base + 32'(k)});
      end
   endtask

   task automatic push_rsp(input int r, input logic [31:0] hdr, input logic [31:0] base,
                           input int nwords);
      exp_rsp_q.push_back({2'(r), hdr});
      for (int k = 1; k < nwords; k++) begin
         exp_rsp_q.push_back({2'(r), base + 32'(k)});
      end
   endtask

   // Requester driver; entered and left at posedge+1.
   task automatic send_pkt(input int r, input logic [31:0] hdr, input logic [31:0] base,
                           input int gap);
      int n = int'(hdr[7:0]) + 1;
      for (int k = 0; k < n; k++) begin
         int   budget = 0;
         logic fire   = 1'b0;
         tb_data[r]  = (k == 0) ? hdr : base + 32'(k);
         tb_valid[r] = 1'b1;
         while (!fire) begin
            @(negedge clk);
            fire = req_bus.req_ready[r];
            @(posedge clk);
            #1;
            budget++;
            if (!fire && budget > BUDGET) begin
               check("req_accept_timeout", 64'd0, 64'd1);
               fire = 1'b1;
            end
         end
         if (gap > 0) begin
            tb_valid[r] = 1'b0;
            step(gap);
         end
      end
      tb_valid[r] = 1'b0;
   endtask

   task automatic core_reply(input logic [31:0] hdr, input logic [31:0] base, input int nwords);
      for (int k = 0; k < nwords; k++) begin
         valid_in_interface = 1'b1;
         in_interface       = (k == 0) ? hdr : base + 32'(k);
         step(1);
      end
      valid_in_interface = 1'b0;
   endtask

   task automatic wait_out(input int target);
      int budget = 0;
      while (n_out < target && budget < BUDGET) begin
         step(1);
         budget++;
      end
      if (n_out < target) check("wait_out_timeout", 64'(n_out), 64'(target));
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
      check({tag, "_err"}, 64'(err), 64'd0);
      check({tag, "_valid_out"}, 64'(valid_out_interface), 64'd0);
      check({tag, "_out_data"}, 64'(out_interface), 64'd0);
      check({tag, "_rsp_valid"}, 64'(req_bus.rsp_valid), 64'd0);
      check({tag, "_rsp_data"}, 64'(req_bus.rsp_data), 64'd0);
      check({tag, "_req_ready"}, 64'(req_bus.req_ready), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, e0, e1, r0, budget;
      for (int i = 0; i < NREQ; i++) begin
         tb_valid[i] = 1'b0;
         tb_data[i]  = '0;
      end
      #1 reset = 1'b0;
      #2 check_idle_outputs("reset");
      step(3);
      reset = 1'b1;
      step(1);

      // 1: single req0 packet, LEN=2; response LEN=1
      push_out(0, 32'h0000_0002, 32'hA0);
      push_rsp(0, 32'h0000_0001, 32'hB0, 2);
      send_pkt(0, 32'h0000_0002, 32'hA0, 0);
      wait_out(3);
      check("t1_busy_wait", 64'(busy), 64'd1);
      check("t1_grant", 64'(grant_id), 64'd0);
      core_reply(32'h0000_0001, 32'hB0, 2);
      check("t1_busy_done", 64'(busy), 64'd0);
      step(2);
      check("t1_rsp_count", 64'(n_rsp), 64'd2);

      // 2: both requesters after reset: req0, req1, then req0 again
      reset = 1'b0;
      step(2);
      reset = 1'b1;
      step(1);
      n0 = n_out;
      push_out(0, 32'h0A00_0001, 32'hC0);
      push_out(1, 32'h1A00_0000, 32'h0);
      push_out(0, 32'h0B00_0003, 32'hD0);
      push_rsp(0, 32'h5000_0000, 32'h0, 1);
      push_rsp(1, 32'h5100_0002, 32'hE0, 3);
      push_rsp(0, 32'h5200_0001, 32'hF0, 2);
      fork
         begin
            send_pkt(0, 32'h0A00_0001, 32'hC0, 0);
            send_pkt(0, 32'h0B00_0003, 32'hD0, 0);
         end
         send_pkt(1, 32'h1A00_0000, 32'h0, 0);
         begin
            wait_out(n0 + 2);
            core_reply(32'h5000_0000, 32'h0, 1);
            wait_out(n0 + 3);
            core_reply(32'h5100_0002, 32'hE0, 3);
            wait_out(n0 + 7);
            core_reply(32'h5200_0001, 32'hF0, 2);
         end
      join
      check("t2_busy_done", 64'(busy), 64'd0);

      // 3: LEN=0 each way from req1; header-only response ends the packet
      n0 = n_out;
      push_out(1, 32'h3C00_0000, 32'h0);
      push_rsp(1, 32'h6C00_0000, 32'h0, 1);
      send_pkt(1, 32'h3C00_0000, 32'h0, 0);
      wait_out(n0 + 1);
      core_reply(32'h6C00_0000, 32'h0, 1);
      check("t3_busy_after_hdr", 64'(busy), 64'd0);
      step(2);

      // 4: core silent -> timeout after TMO_CYC idle cycles
      n0 = n_out;
      e0 = n_err0;
      r0 = n_rsp;
      push_out(0, 32'h4D00_0001, 32'h70);
      send_pkt(0, 32'h4D00_0001, 32'h70, 0);
      wait_out(n0 + 2);
      budget = 0;
      while (n_err0 == e0 && budget < TMO_CYC + 50) begin
         step(1);
         budget++;
      end
      check("t4_err0_seen", 64'(n_err0 - e0), 64'd1);
      check("t4_tmo_cycles", 64'(err0_cyc - last_out_cyc), 64'(TMO_CYC));
      check("t4_busy", 64'(busy), 64'd0);
      step(3);
      check("t4_err0_width", 64'(n_err0 - e0), 64'd1);
      check("t4_no_rsp", 64'(n_rsp - r0), 64'd0);

      // 5: rr advanced past timed-out req0 -> req1 first; stray word during FWD
      n0 = n_out;
      e1 = n_err1;
      push_out(1, 32'h5F00_0003, 32'h90);
      push_out(0, 32'h5E00_0001, 32'h80);
      push_rsp(1, 32'h7100_0001, 32'h30, 2);
      push_rsp(0, 32'h7200_0000, 32'h0, 1);
      fork
         send_pkt(0, 32'h5E00_0001, 32'h80, 0);
         send_pkt(1, 32'h5F00_0003, 32'h90, 3);
         begin
            wait_out(n0 + 1);
            step(1);
            valid_in_interface = 1'b1;
            in_interface       = 32'hDEAD_BEEF;
            step(1);
            valid_in_interface = 1'b0;
            step(1);
            check("t5_err1", 64'(n_err1 - e1), 64'd1);
            check("t5_busy_fwd", 64'(busy), 64'd1);
            wait_out(n0 + 4);
            core_reply(32'h7100_0001, 32'h30, 2);
            wait_out(n0 + 6);
            core_reply(32'h7200_0000, 32'h0, 1);
         end
      join
      check("t5_busy_done", 64'(busy), 64'd0);
      step(2);

      // 6: reset in the middle of a response, then a clean req1 packet
      n0 = n_out;
      push_out(1, 32'h6100_0000, 32'h0);
      push_rsp(1, 32'h7300_0003, 32'h40, 2);
      send_pkt(1, 32'h6100_0000, 32'h0, 0);
      wait_out(n0 + 1);
      core_reply(32'h7300_0003, 32'h40, 2);
      @(negedge clk);
      #1 reset = 1'b0;
      #1 check_idle_outputs("midrsp_reset");
      step(2);
      reset = 1'b1;
      step(1);
      n0 = n_out;
      push_out(1, 32'h6200_0001, 32'h20);
      push_rsp(1, 32'h7400_0001, 32'h50, 2);
      send_pkt(1, 32'h6200_0001, 32'h20, 0);
      wait_out(n0 + 2);
      core_reply(32'h7400_0001, 32'h50, 2);
      check("t6_busy_done", 64'(busy), 64'd0);
      step(3);

      check("end_out_q_empty", 64'(exp_out_q.size()), 64'd0);
      check("end_rsp_q_empty", 64'(exp_rsp_q.size()), 64'd0);
      check("end_err0_total", 64'(n_err0), 64'd1);
      check("end_err1_total", 64'(n_err1), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
